// File: rtl/fifo_wc_pkg.sv
// Shared definitions for the width-conversion FIFO slice: default widths and
// the write-arbiter state encoding, reused by the FIFO controller and register file.
package fifo_wc_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int BURST_LEN_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arbState_e;

endpackage

// File: rtl/fifo_wc_write_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic o_pick,
  output logic o_valid
);

  always_comb begin
    o_valid = req0 | req1;
    o_pick  = 1'b0;
    if (req0 && req1) begin
      o_pick = ~last_served;
    end else if (req1) begin
      o_pick = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wc_write_arbiter.sv
// Write-side arbiter sharing one FIFO write port between two bursting producers,
// with round-robin fairness and a bounded number of words per grant.
module fifo_wc_write_arbiter
  import fifo_wc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  last0,
  input  logic                  last1,
  input  logic                  full,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  grant0,
  output logic                  grant1
);

  arbState_e              r_state;
  arbState_e              w_nextState;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_nextCnt;
  logic                   r_lastServed;
  logic                   w_nextLastServed;
  logic                   w_grantIdx;
  logic                   w_pickLastServed;
  logic                   w_pick;
  logic                   w_pickValid;
  logic                   w_reqGranted;
  logic                   w_lastGranted;
  logic                   w_cntAtMax;
  logic                   w_release;

  assign grant0     = (r_state == GNT0);
  assign grant1     = (r_state == GNT1);
  assign w_grantIdx = (r_state == GNT1);
  assign w_cntAtMax = (r_cnt == CNT_WIDTH'(BURST_LEN - 1));

  // In IDLE the tie-break follows the history bit; on release the current
  // holder counts as last served, so a waiting peer always wins the handover.
  assign w_pickLastServed = (r_state == IDLE) ? r_lastServed : w_grantIdx;

  rr_pick2 u_rrPick (
    .req0        (req0),
    .req1        (req1),
    .last_served (w_pickLastServed),
    .o_pick      (w_pick),
    .o_valid     (w_pickValid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_lastServed <= 1'b1;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      r_lastServed <= w_nextLastServed;
    end
  end

  // Write strobe is also masked by reset so an aborted burst never writes.
  always_comb begin
    w_nextState      = r_state;
    w_nextCnt        = r_cnt;
    w_nextLastServed = r_lastServed;
    w_reqGranted     = 1'b0;
    w_lastGranted    = 1'b0;
    w_data           = '0;
    w_release        = 1'b0;

    case (r_state)
      GNT0: begin
        w_reqGranted  = req0;
        w_lastGranted = last0;
        w_data        = wdata0;
      end
      GNT1: begin
        w_reqGranted  = req1;
        w_lastGranted = last1;
        w_data        = wdata1;
      end
      default: begin
        w_reqGranted  = 1'b0;
      end
    endcase

    wr   = (r_state != IDLE) & w_reqGranted & ~full & reset;
    ack0 = wr & grant0;
    ack1 = wr & grant1;

    if (r_state == IDLE) begin
      if (w_pickValid) begin
        w_nextState = w_pick ? GNT1 : GNT0;
      end
    end else begin
      w_release = (wr && (w_lastGranted || w_cntAtMax)) || !w_reqGranted;
      if (w_release) begin
        w_nextLastServed = w_grantIdx;
        w_nextCnt        = '0;
        if (w_pickValid) begin
          w_nextState = w_pick ? GNT1 : GNT0;
        end else begin
          w_nextState = IDLE;
        end
      end else if (wr) begin
        w_nextCnt = r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_wc_write_arbiter.sv
// Scenario bench for fifo_wc_write_arbiter: producers drain word queues on ack,
// and every written word is matched against an in-order expected-write queue.
module tb_fifo_wc_write_arbiter;

  localparam int DW = 16;
  localparam int BL = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          last0 = 1'b0;
  logic          last1 = 1'b0;
  logic          full = 1'b0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic          wr;
  logic [DW-1:0] w_data;
  logic          ack0;
  logic          ack1;
  logic          grant0;
  logic          grant1;

  int checks = 0;
  int errors = 0;
  int cycleNum = 0;
  int firstWr = -1;
  int lastWr = -1;
  int wrCount = 0;

  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  logic [DW:0] sb[$];
  logic        fullNext = 1'b0;
  logic        resetNext = 1'b0;
  logic        sawAck0 = 1'b0;
  logic        sawAck1 = 1'b0;

  fifo_wc_write_arbiter #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .last0  (last0),
    .last1  (last1),
    .full   (full),
    .wr     (wr),
    .w_data (w_data),
    .ack0   (ack0),
    .ack1   (ack1),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleNum);
    end
  endtask

  task automatic pushWord(input bit p, input logic [DW-1:0] data, input bit last);
    if (p) q1.push_back({last, data});
    else   q0.push_back({last, data});
  endtask

  task automatic expectWord(input bit p, input logic [DW-1:0] data);
    sb.push_back({p, data});
  endtask

  task automatic driveProducers();
    req0 = 1'b0; wdata0 = '0; last0 = 1'b0;
    req1 = 1'b0; wdata1 = '0; last1 = 1'b0;
    if (q0.size() > 0) begin
      req0 = 1'b1; wdata0 = q0[0][DW-1:0]; last0 = q0[0][DW];
    end
    if (q1.size() > 0) begin
      req1 = 1'b1; wdata1 = q1[0][DW-1:0]; last1 = q1[0][DW];
    end
  endtask

  task automatic monitor();
    logic [DW:0] exp;
    if (wr) begin
      wrCount++;
      if (firstWr < 0) firstWr = cycleNum;
      lastWr = cycleNum;
      if (sb.size() == 0) begin
        checkOutput("unexpectedWr", 32'(wr), 32'd0);
      end else begin
        exp = sb.pop_front();
        checkOutput("wData", 32'(w_data), 32'(exp[DW-1:0]));
        checkOutput("ackSel", 32'({ack1, ack0}), exp[DW] ? 32'd2 : 32'd1);
      end
    end else begin
      checkOutput("ackNoWr", 32'({ack1, ack0}), 32'd0);
    end
    sawAck0 = ack0;
    sawAck1 = ack1;
  endtask

  // One clock cycle: retire acked words, drive the next inputs, sample at negedge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (sawAck0 && q0.size() > 0) void'(q0.pop_front());
    if (sawAck1 && q1.size() > 0) void'(q1.pop_front());
    sawAck0 = 1'b0;
    sawAck1 = 1'b0;
    full  = fullNext;
    reset = resetNext;
    driveProducers();
    cycleNum++;
    @(negedge clk);
    monitor();
  endtask

  task automatic resetDut();
    resetNext = 1'b0;
    fullNext  = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) applyStimulus();
    resetNext = 1'b1;
  endtask

  initial begin
    // Reset state
    resetDut();
    checkOutput("rstGrant", 32'({grant1, grant0}), 32'd0);
    checkOutput("rstWr", 32'(wr), 32'd0);
    checkOutput("rstData", 32'(w_data), 32'd0);

    // Single producer, three words ending in last0
    for (int i = 0; i < 3; i++) begin
      pushWord(1'b0, DW'(16'h1100 + i), i == 2);
      expectWord(1'b0, DW'(16'h1100 + i));
    end
    applyStimulus();
    checkOutput("s1IdleGrant", 32'(grant0), 32'd0);
    checkOutput("s1IdleWr", 32'(wr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("s1StreamWr", 32'(wr), 32'd1);
    end
    repeat (2) applyStimulus();
    checkOutput("s1BackIdle", 32'({grant1, grant0}), 32'd0);
    checkOutput("s1Drained", 32'(sb.size()), 32'd0);

    // Contention: continuous streams, bursts of BL alternate 0,1,0,1
    resetDut();
    for (int i = 0; i < 8; i++) begin
      pushWord(1'b0, DW'(16'h2000 + i), 1'b0);
      pushWord(1'b1, DW'(16'h2100 + i), 1'b0);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < BL; i++) expectWord(1'b0, DW'(16'h2000 + b * BL + i));
      for (int i = 0; i < BL; i++) expectWord(1'b1, DW'(16'h2100 + b * BL + i));
    end
    firstWr = -1; lastWr = -1; wrCount = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("s2FirstGrant", 32'({grant1, grant0}), 32'd1);
    repeat (17) applyStimulus();
    checkOutput("s2WrCount", 32'(wrCount), 32'd16);
    checkOutput("s2NoBubble", 32'(lastWr - firstWr + 1), 32'd16);
    checkOutput("s2Drained", 32'(sb.size()), 32'd0);
    checkOutput("s2BackIdle", 32'({grant1, grant0}), 32'd0);

    // Full stall in GNT1 after two accepts
    resetDut();
    for (int i = 0; i < 4; i++) begin
      pushWord(1'b1, DW'(16'h3100 + i), 1'b0);
      expectWord(1'b1, DW'(16'h3100 + i));
    end
    repeat (3) applyStimulus();
    fullNext = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("s3StallWr", 32'(wr), 32'd0);
      checkOutput("s3StallGrant", 32'(grant1), 32'd1);
      checkOutput("s3StallCnt", 32'(dut.r_cnt), 32'd2);
    end
    fullNext = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("s3ResumeWr", 32'(wr), 32'd1);
    end
    repeat (2) applyStimulus();
    checkOutput("s3Released", 32'(grant1), 32'd0);
    checkOutput("s3Drained", 32'(sb.size()), 32'd0);

    // Early last0 with req1 pending hands over with no bubble
    resetDut();
    pushWord(1'b0, DW'(16'h4000), 1'b1);
    pushWord(1'b1, DW'(16'h4100), 1'b0);
    pushWord(1'b1, DW'(16'h4101), 1'b0);
    expectWord(1'b0, DW'(16'h4000));
    expectWord(1'b1, DW'(16'h4100));
    expectWord(1'b1, DW'(16'h4101));
    repeat (2) applyStimulus();
    applyStimulus();
    checkOutput("s4Grant1", 32'({grant1, grant0}), 32'd2);
    checkOutput("s4LastServed", 32'(dut.r_lastServed), 32'd0);
    checkOutput("s4NoBubble", 32'(wr), 32'd1);
    repeat (3) applyStimulus();
    checkOutput("s4Drained", 32'(sb.size()), 32'd0);

    // Abandon: req1 drops mid-burst
    resetDut();
    pushWord(1'b1, DW'(16'h5100), 1'b0);
    pushWord(1'b1, DW'(16'h5101), 1'b0);
    expectWord(1'b1, DW'(16'h5100));
    expectWord(1'b1, DW'(16'h5101));
    repeat (3) applyStimulus();
    applyStimulus();
    checkOutput("s5AbandonGrant", 32'(grant1), 32'd1);
    checkOutput("s5AbandonWr", 32'(wr), 32'd0);
    applyStimulus();
    checkOutput("s5Idle", 32'({grant1, grant0}), 32'd0);
    checkOutput("s5Cnt", 32'(dut.r_cnt), 32'd0);
    checkOutput("s5Drained", 32'(sb.size()), 32'd0);

    // Reset mid-burst in GNT0 with cnt = 2, then producer 0 wins the first tie
    resetDut();
    for (int i = 0; i < 6; i++) pushWord(1'b0, DW'(16'h6000 + i), 1'b0);
    for (int i = 0; i < 4; i++) pushWord(1'b1, DW'(16'h6100 + i), 1'b0);
    expectWord(1'b0, DW'(16'h6000));
    expectWord(1'b0, DW'(16'h6001));
    repeat (3) applyStimulus();
    resetNext = 1'b0;
    applyStimulus();
    checkOutput("s6PreRstCnt", 32'(dut.r_cnt), 32'd2);
    checkOutput("s6RstCycleWr", 32'(wr), 32'd0);
    resetNext = 1'b1;
    applyStimulus();
    checkOutput("s6PostRstGrant", 32'({grant1, grant0}), 32'd0);
    checkOutput("s6PostRstWr", 32'(wr), 32'd0);
    checkOutput("s6PostRstData", 32'(w_data), 32'd0);
    checkOutput("s6PostRstCnt", 32'(dut.r_cnt), 32'd0);
    expectWord(1'b0, DW'(16'h6002));
    applyStimulus();
    checkOutput("s6FirstTie", 32'({grant1, grant0}), 32'd1);
    checkOutput("s6Drained", 32'(sb.size()), 32'd0);
    resetDut();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
